control_seq: RTL and testbench

- Parametrised successor to the register-transfer control decoder of the 8080-subset datapath.
- Owns its own step counter and instruction register, and fetches opcodes and immediates over a valid/ready handshake.
- Generalises register selects and enables to one-hot vectors indexed by the 8080 register code.
- Adds ALU-group logical ops, CMP, NOP, illegal-opcode detection, an immediate-wait timeout and a retired-instruction counter.

---
 rtl/control_seq.sv | 128 ++++++++++++
 tb/tb_control_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// control_seq: 8080-subset register-transfer control sequencer with its own fetch handshake.
// Define CTRL_LOGIC_OPS_EN to decode ANA/XRA/ORA/CMP; otherwise those opcodes are illegal.
module control_seq #(
   parameter int STEP_W      = 2,
   parameter int MVI_TIMEOUT = 0,
   parameter int CNT_W       = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        instr_in,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic              data_in_select,
   output logic [7:0]        reg_select,
   output logic [7:0]        reg_enable,
   output logic              const_select,
   output logic              r1_enable,
   output logic              r2_enable,
   output logic              r2_select,
   output logic [2:0]        alu_op,
   output logic              flags_enable,
   output logic              done,
   output logic              illegal,
   output logic [STEP_W-1:0] step,
   output logic [CNT_W-1:0]  instr_count
);
   localparam int TW = MVI_TIMEOUT > 0 ? $clog2(MVI_TIMEOUT + 1) : 1;

   typedef enum logic {FETCH, EXEC} state_t;

   state_t        state, nextState;
   logic [7:0]    ir;
   logic [TW-1:0] stallCnt;
   logic [1:0]    grp;
   logic [2:0]    dst, src, aluCode;
   logic          isNop, isMvi, isIncDec, isMov, isAlu, legal, timedOut, logicOk;

   function automatic logic [7:0] oneHot(input logic [2:0] code);
      return 8'b1 << code;
   endfunction

`ifdef CTRL_LOGIC_OPS_EN
   assign logicOk = 1'b1;
`else
   assign logicOk = 1'b0;
`endif

   assign grp      = ir[7:6];
   assign dst      = ir[5:3];
   assign src      = ir[2:0];
   assign isNop    = ir == 8'h00;
   assign isMvi    = grp == 2'b00 && src == 3'b110 && dst != 3'b110;
   assign isIncDec = grp == 2'b00 && src[2:1] == 2'b10 && dst != 3'b110;
   assign isMov    = grp == 2'b01 && dst != 3'b110 && src != 3'b110;
   // ADC/SBB are never supported; the logical half of the group depends on the build
   assign isAlu    = grp == 2'b10 && src != 3'b110 && (dst[2] ? logicOk : !dst[0]);
   assign legal    = isNop | isMvi | isIncDec | isMov | isAlu;
   assign timedOut = MVI_TIMEOUT > 0 && stallCnt == TW'(MVI_TIMEOUT);
   assign aluCode  = isAlu ? dst : {1'b0, src[0], 1'b0};

   always_ff @(posedge clock or posedge reset)
      if (reset) state <= FETCH;
      else state <= nextState;

   always_comb
      nextState = state == FETCH ? (instr_valid ? EXEC : FETCH) : (done || illegal ? FETCH : EXEC);

   always_comb begin
      instr_ready    = 1'b0;
      data_in_select = 1'b0;
      reg_select     = '0;
      reg_enable     = '0;
      const_select   = 1'b0;
      r1_enable      = 1'b0;
      r2_enable      = 1'b0;
      r2_select      = 1'b0;
      alu_op         = '0;
      flags_enable   = 1'b0;
      done           = 1'b0;
      illegal        = 1'b0;
      if (!reset && state == FETCH) instr_ready = 1'b1;
      else if (!reset) begin
         if (!legal || (isMvi && timedOut)) illegal = 1'b1;
         else if (isNop) done = 1'b1;
         else if (isMvi) begin
            instr_ready    = 1'b1;
            data_in_select = 1'b1;
            reg_enable     = instr_valid ? oneHot(dst) : '0;
            done           = instr_valid;
         end else if (isMov) begin
            reg_select = oneHot(src);
            reg_enable = oneHot(dst);
            done       = 1'b1;
         end else if (step == '0) begin
            reg_select   = isAlu ? oneHot(3'd7) : '0;
            const_select = !isAlu;
            r1_enable    = 1'b1;
         end else if (step == STEP_W'(1)) begin
            reg_select = oneHot(isAlu ? src : dst);
            r2_enable  = 1'b1;
            alu_op     = aluCode;
         end else begin
            r2_select    = 1'b1;
            flags_enable = 1'b1;
            done         = 1'b1;
            alu_op       = isAlu ? aluCode : '0;
            reg_enable   = !isAlu ? oneHot(dst) : (dst == 3'b111 ? '0 : oneHot(3'd7));
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ir          <= '0;
         step        <= '0;
         instr_count <= '0;
         stallCnt    <= '0;
      end else if (state == FETCH) begin
         if (instr_valid) ir <= instr_in;
         step     <= '0;
         stallCnt <= '0;
      end else begin
         step     <= done || illegal ? '0 : isMvi ? step : step + STEP_W'(1);
         stallCnt <= MVI_TIMEOUT > 0 && isMvi && !instr_valid ? stallCnt + TW'(1) : '0;
         if (done) instr_count <= instr_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: scoreboard bench for control_seq; one default instance and one with MVI_TIMEOUT=4.
module tb_control_seq;
   logic       clk, rst, instrValid;
   logic [7:0] instrIn;

   logic       rdy, dsel, csel, r1e, r2e, r2s, fle, dn, ill;
   logic [7:0] rsel, ren;
   logic [2:0] aop;
   logic [1:0] stp;
   logic [15:0] cnt;
   logic       rdyT, dselT, cselT, r1eT, r2eT, r2sT, fleT, dnT, illT;
   logic [7:0] rselT, renT;
   logic [2:0] aopT;
   logic [1:0] stpT;
   logic [15:0] cntT;

   logic [29:0] obs, obsT;
   assign obs  = {stp, rdy, dsel, rsel, ren, csel, r1e, r2e, r2s, aop, fle, dn, ill};
   assign obsT = {stpT, rdyT, dselT, rselT, renT, cselT, r1eT, r2eT, r2sT, aopT, fleT, dnT, illT};

   localparam logic [29:0] FE  = 30'h0800_0000;
   localparam logic [29:0] ILL = 30'h0000_0001;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic [29:0] e;
   } ent_t;

   ent_t sb[$];
   int nCmp = 0;
   int nErr = 0;
   int expCount = 0;

   control_seq dut (
      .clock(clk), .reset(rst), .instr_in(instrIn), .instr_valid(instrValid),
      .instr_ready(rdy), .data_in_select(dsel), .reg_select(rsel), .reg_enable(ren),
      .const_select(csel), .r1_enable(r1e), .r2_enable(r2e), .r2_select(r2s),
      .alu_op(aop), .flags_enable(fle), .done(dn), .illegal(ill),
      .step(stp), .instr_count(cnt)
   );

   control_seq #(.MVI_TIMEOUT(4)) dutT (
      .clock(clk), .reset(rst), .instr_in(instrIn), .instr_valid(instrValid),
      .instr_ready(rdyT), .data_in_select(dselT), .reg_select(rselT), .reg_enable(renT),
      .const_select(cselT), .r1_enable(r1eT), .r2_enable(r2eT), .r2_select(r2sT),
      .alu_op(aopT), .flags_enable(fleT), .done(dnT), .illegal(illT),
      .step(stpT), .instr_count(cntT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [29:0] mk(logic [1:0] st, logic rd, logic ds, logic [7:0] rs,
                                      logic [7:0] re, logic cs, logic e1, logic e2, logic s2,
                                      logic [2:0] op, logic fl, logic d, logic il);
      return {st, rd, ds, rs, re, cs, e1, e2, s2, op, fl, d, il};
   endfunction

   function automatic void push(logic v, logic [7:0] d, logic [29:0] e);
      sb.push_back('{v, d, e});
   endfunction

   task automatic stepOne(output logic [29:0] e, output logic [29:0] o, output logic [29:0] oT);
      ent_t x;
      x = sb.pop_front();
      @(negedge clk);
      instrValid = x.v;
      instrIn    = x.d;
      #1;
      e  = x.e;
      o  = obs;
      oT = obsT;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      instrValid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      expCount = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      instrValid = 1'b1;
      instrIn = 8'h3E;
      #1;
      nCmp++;
      if (obs !== 30'h0 || obsT !== 30'h0) begin
         nErr++;
         $display("FAIL reset_outputs: got %h/%h want 0", obs, obsT);
      end
      @(negedge clk);
      nCmp++;
      if (obs !== 30'h0 || cnt !== 16'h0) begin
         nErr++;
         $display("FAIL reset_held: got %h cnt %h want 0", obs, cnt);
      end
      rst = 1'b0;
      instrValid = 1'b0;
      expCount = 0;
   endtask

   task automatic test_mvi();
      logic [29:0] e, o, oT;
      push(1, 8'h3E, FE);
      push(1, 8'h5A, mk(0, 1, 1, 8'h00, 8'h80, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      push(0, 8'h00, FE);
      push(1, 8'h06, FE);
      for (int i = 0; i < 6; i++) push(0, 8'h00, mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0, 0));
      push(1, 8'h11, mk(0, 1, 1, 8'h00, 8'h01, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      push(0, 8'h00, FE);
      expCount += 2;
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (o !== e) begin
            nErr++;
            $display("FAIL mvi: got %h want %h", o, e);
         end
      end
      nCmp++;
      if (cnt !== 16'(expCount)) begin
         nErr++;
         $display("FAIL mvi_count: got %0d want %0d", cnt, expCount);
      end
   endtask

   task automatic test_mov();
      logic [29:0] e, o, oT;
      push(1, 8'h78, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h01, 8'h80, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      push(1, 8'h6B, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h08, 8'h20, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      push(0, 8'h00, FE);
      expCount += 2;
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (o !== e) begin
            nErr++;
            $display("FAIL mov: got %h want %h", o, e);
         end
      end
      nCmp++;
      if (cnt !== 16'(expCount)) begin
         nErr++;
         $display("FAIL mov_count: got %0d want %0d", cnt, expCount);
      end
   endtask

   task automatic test_alu();
      logic [29:0] e, o, oT;
      push(1, 8'h91, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h80, 8'h00, 0, 1, 0, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(1, 0, 0, 8'h02, 8'h00, 0, 0, 1, 0, 3'b010, 0, 0, 0));
      push(0, 8'h00, mk(2, 0, 0, 8'h00, 8'h80, 0, 0, 0, 1, 3'b010, 1, 1, 0));
      push(1, 8'h84, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h80, 8'h00, 0, 1, 0, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(1, 0, 0, 8'h10, 8'h00, 0, 0, 1, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(2, 0, 0, 8'h00, 8'h80, 0, 0, 0, 1, 3'b000, 1, 1, 0));
      expCount += 2;
      push(1, 8'h88, FE);
      push(0, 8'h00, ILL);
`ifdef CTRL_LOGIC_OPS_EN
      push(1, 8'hBA, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h80, 8'h00, 0, 1, 0, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(1, 0, 0, 8'h04, 8'h00, 0, 0, 1, 0, 3'b111, 0, 0, 0));
      push(0, 8'h00, mk(2, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 3'b111, 1, 1, 0));
      push(1, 8'hB3, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h80, 8'h00, 0, 1, 0, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(1, 0, 0, 8'h08, 8'h00, 0, 0, 1, 0, 3'b110, 0, 0, 0));
      push(0, 8'h00, mk(2, 0, 0, 8'h00, 8'h80, 0, 0, 0, 1, 3'b110, 1, 1, 0));
      expCount += 2;
`else
      push(1, 8'hBA, FE);
      push(0, 8'h00, ILL);
      push(1, 8'hB3, FE);
      push(0, 8'h00, ILL);
`endif
      push(0, 8'h00, FE);
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (o !== e) begin
            nErr++;
            $display("FAIL alu: got %h want %h", o, e);
         end
      end
      nCmp++;
      if (cnt !== 16'(expCount)) begin
         nErr++;
         $display("FAIL alu_count: got %0d want %0d", cnt, expCount);
      end
   endtask

   task automatic test_incdec();
      logic [29:0] e, o, oT;
      push(1, 8'h0D, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(1, 0, 0, 8'h02, 8'h00, 0, 0, 1, 0, 3'b010, 0, 0, 0));
      push(0, 8'h00, mk(2, 0, 0, 8'h00, 8'h02, 0, 0, 0, 1, 3'b000, 1, 1, 0));
      push(1, 8'h3C, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(1, 0, 0, 8'h80, 8'h00, 0, 0, 1, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, mk(2, 0, 0, 8'h00, 8'h80, 0, 0, 0, 1, 3'b000, 1, 1, 0));
      push(0, 8'h00, FE);
      expCount += 2;
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (o !== e) begin
            nErr++;
            $display("FAIL incdec: got %h want %h", o, e);
         end
      end
      nCmp++;
      if (cnt !== 16'(expCount)) begin
         nErr++;
         $display("FAIL incdec_count: got %0d want %0d", cnt, expCount);
      end
   endtask

   task automatic test_illegal();
      logic [29:0] e, o, oT;
      logic [7:0] bad[4] = '{8'h76, 8'h36, 8'h08, 8'hC3};
      foreach (bad[i]) begin
         push(1, bad[i], FE);
         push(0, 8'h00, ILL);
      end
      push(1, 8'h00, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      push(0, 8'h00, FE);
      expCount += 1;
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (o !== e) begin
            nErr++;
            $display("FAIL illegal: got %h want %h", o, e);
         end
      end
      nCmp++;
      if (cnt !== 16'(expCount)) begin
         nErr++;
         $display("FAIL illegal_count: got %0d want %0d", cnt, expCount);
      end
   endtask

   task automatic test_timeout();
      logic [29:0] e, o, oT;
      doReset();
      push(1, 8'h06, FE);
      for (int i = 0; i < 4; i++) push(0, 8'h00, mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0, 0));
      push(0, 8'h00, ILL);
      push(0, 8'h00, FE);
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (oT !== e) begin
            nErr++;
            $display("FAIL timeout: got %h want %h", oT, e);
         end
      end
      nCmp++;
      if (cntT !== 16'h0) begin
         nErr++;
         $display("FAIL timeout_count: got %0d want 0", cntT);
      end
   endtask

   task automatic test_reset_mid();
      logic [29:0] e, o, oT;
      doReset();
      push(1, 8'h91, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h80, 8'h00, 0, 1, 0, 0, 3'b000, 0, 0, 0));
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (o !== e) begin
            nErr++;
            $display("FAIL reset_mid_pre: got %h want %h", o, e);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      nCmp++;
      if (obs !== 30'h0 || obsT !== 30'h0 || cnt !== 16'h0) begin
         nErr++;
         $display("FAIL reset_mid_abort: got %h/%h cnt %0d want 0", obs, obsT, cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      push(0, 8'h00, FE);
      push(1, 8'h00, FE);
      push(0, 8'h00, mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      push(0, 8'h00, FE);
      while (sb.size() > 0) begin
         stepOne(e, o, oT);
         nCmp++;
         if (o !== e) begin
            nErr++;
            $display("FAIL reset_mid_post: got %h want %h", o, e);
         end
      end
      nCmp++;
      if (cnt !== 16'h1) begin
         nErr++;
         $display("FAIL reset_mid_count: got %0d want 1", cnt);
      end
   endtask

   initial begin
      test_reset();
      test_mvi();
      test_mov();
      test_alu();
      test_incdec();
      test_illegal();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, %0d compared", nCmp);
      $fatal(1);
   end
endmodule
